// File: rtl/uart_tx.sv
// uart_tx: serializes one frame per acceptance, one CLK per bit, optional even/odd parity.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] data, data_nxt;
    logic                  pen, pen_nxt, ptyp, ptyp_nxt, tx_nxt, accept;

    always_comb begin
        accept    = DATA_VALID && (state == IDLE || state == STOP);
        state_nxt = IDLE;
        cnt_nxt   = cnt;
        data_nxt  = accept ? P_DATA : data;
        pen_nxt   = accept ? PAR_EN : pen;
        ptyp_nxt  = accept ? PAR_TYP : ptyp;
        case (state)
            IDLE:    state_nxt = accept ? START : IDLE;
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                state_nxt = (cnt == LAST) ? (pen ? PARITY : STOP) : DATA;
                cnt_nxt   = (cnt == LAST) ? cnt : cnt + CW'(1);
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
        // TX_OUT is registered, so the line value is derived from the next state
        tx_nxt = (state_nxt == START)  ? 1'b0 :
                 (state_nxt == DATA)   ? data_nxt[cnt_nxt] :
                 (state_nxt == PARITY) ? (^data_nxt) ^ ptyp_nxt : 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            data   <= '0;
            pen    <= 1'b0;
            ptyp   <= 1'b0;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data   <= data_nxt;
            pen    <= pen_nxt;
            ptyp   <= ptyp_nxt;
            TX_OUT <= tx_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal range 5..8).
REQ-002 SHALL have port CLK, input, 1, bit-rate clock; one CLK period equals one serial bit time.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH, parallel payload, sampled only on acceptance.
REQ-005 SHALL have port DATA_VALID, input, 1, request to send P_DATA.
REQ-006 SHALL have port PAR_EN, input, 1, 1 = append parity bit, sampled only on acceptance.
REQ-007 SHALL have port PAR_TYP, input, 1, 0 = even, 1 = odd, sampled only on acceptance.
REQ-008 SHALL have port TX_OUT, output, 1, registered serial line; idle level 1.
REQ-009 SHALL have port busy, output, 1, registered; high while a frame bit is on TX_OUT.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-011 Acceptance SHALL occur at a CLK rising edge where DATA_VALID=1 and the state is IDLE, or STOP with its bit in its final cycle.
REQ-012 On acceptance SHALL latch P_DATA, PAR_EN and PAR_TYP into a frame register and enter START.
REQ-013 Once latched, the frame register SHALL NOT change until the next acceptance; P_DATA, PAR_EN and PAR_TYP changes mid-frame SHALL have no effect.
REQ-014 DATA_VALID outside an acceptance edge SHALL be ignored; no queueing, no dropped-request flag.
REQ-015 START SHALL drive TX_OUT=0 for exactly 1 cycle, starting in the cycle after acceptance.
REQ-016 DATA SHALL drive latched bits LSB first, 1 cycle each, for DATA_WIDTH cycles, using a bit counter that counts 0..DATA_WIDTH-1.
REQ-017 After the last data bit, the FSM SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-018 PARITY SHALL drive, for 1 cycle, XOR of latched data when PAR_TYP=0, or its inverse when PAR_TYP=1.
REQ-019 STOP SHALL drive TX_OUT=1 for 1 cycle, then enter START on acceptance, else IDLE.
REQ-020 Frame length SHALL be DATA_WIDTH+2 cycles without parity, or DATA_WIDTH+3 cycles with parity (10/11 at default).
REQ-021 Back-to-back frames SHALL have no idle cycle between the STOP of one frame and the START of the next.
REQ-022 busy SHALL be 1 in every cycle the FSM is in START, DATA, PARITY or STOP, and 0 in IDLE.
REQ-023 busy SHALL stay 1 across a back-to-back boundary.
REQ-024 IDLE SHALL drive TX_OUT=1.
REQ-025 TX_OUT SHALL be glitch-free, driven directly from a flop and not from combinational muxing.
REQ-026 Illegal or unused state encodings SHALL return to IDLE on the next edge with TX_OUT=1.

Reset
REQ-027 RST=0 SHALL immediately force state=IDLE, TX_OUT=1, busy=0, bit counter=0 and frame register=0, independent of CLK.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no partial stop or parity bit.
REQ-029 After reset, the first acceptance edge SHALL be the first CLK rising edge with RST=1 and DATA_VALID=1.
REQ-030 DATA_VALID held high during reset SHALL NOT cause acceptance until RST deasserts.

Verification
REQ-031 Bench SHALL cover: P_DATA=0xA5, PAR_EN=0, single DATA_VALID pulse -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, busy high for those 10 cycles, then TX_OUT=1 and busy=0.
REQ-032 Bench SHALL cover: P_DATA=0x03, PAR_EN=1, PAR_TYP=0 -> 11-cycle frame with parity bit 0; repeat with PAR_TYP=1 -> parity bit 1.
REQ-033 Bench SHALL cover: DATA_VALID held high, P_DATA=0x55 then 0x0F presented at the STOP-cycle edge -> two contiguous 10-cycle frames, busy never drops, second payload 0x0F LSB first.
REQ-034 Bench SHALL cover: DATA_VALID pulsed and P_DATA changed to 0xFF during DATA of a 0x00 frame -> data bits all 0 and no extra frame produced.
REQ-035 Bench SHALL cover: RST pulled low during bit 4 of a frame -> TX_OUT=1 and busy=0 within the reset cycle, and a new DATA_VALID after release yields a clean full frame.
REQ-036 Bench SHALL cover: DATA_WIDTH=7, P_DATA=0x7F, PAR_EN=1, PAR_TYP=0 -> 10-cycle frame with 7 ones and parity bit 1.
